// File: rtl/regfile_sb_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_sb_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int REG0     = 0;

    function automatic int clog2(input int n);
        int r = 0;
        int v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write tracker: one bit per register, set on issue, cleared on writeback.
module rf_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    localparam int AW   = clog2(NREG)
) (
    input  logic          clk_i,
    input  logic          nreset_i,
    input  logic          set,
    input  logic [AW-1:0] set_adr,
    input  logic          clr,
    input  logic [AW-1:0] clr_adr,
    output logic [NREG-1:0] vec
);
    logic [NREG-1:0] vec_nxt;

    // Set is applied after clear so an issue colliding with a writeback stays pending.
    always_comb begin
        vec_nxt = vec;
        if (clr) vec_nxt[clr_adr] = 1'b0;
        if (set) vec_nxt[set_adr] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) vec <= '0;
        else           vec <= vec_nxt;
    end
endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with optional write bypass and a pending scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREG     = NREG_DEF,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = clog2(NREG)
) (
    input  logic            clk_i,
    input  logic            nreset_i,
    input  logic [AW-1:0]   ra1_i,
    output logic [XLEN-1:0] rd1_o,
    output logic            busy1_o,
    input  logic [AW-1:0]   ra2_i,
    output logic [XLEN-1:0] rd2_o,
    output logic            busy2_o,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [XLEN-1:0] wd_i,
    input  logic            iss_i,
    input  logic [AW-1:0]   iss_adr_i,
    output logic [NREG-1:0] busy_vec_o
);
    localparam logic [AW-1:0] R0 = AW'(REG0);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] pend;
    logic            wr_ok;
    logic            iss_ok;

    // With a hardwired zero register, writes and issues to it are dropped, so
    // its storage and pending bit stay 0 and reads need no special casing.
    assign wr_ok  = we_i  && !((ZERO_REG != 0) && (wa_i == R0));
    assign iss_ok = iss_i && !((ZERO_REG != 0) && (iss_adr_i == R0));

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wa_i] <= wd_i;
        end
    end

    rf_scoreboard #(.NREG(NREG)) u_sb (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .set      (iss_ok),
        .set_adr  (iss_adr_i),
        .clr      (wr_ok),
        .clr_adr  (wa_i),
        .vec      (pend)
    );

    assign busy_vec_o = pend;

    always_comb begin
        rd1_o   = mem[ra1_i];
        busy1_o = pend[ra1_i];
        rd2_o   = mem[ra2_i];
        busy2_o = pend[ra2_i];
        if ((BYPASS != 0) && wr_ok && (wa_i == ra1_i)) begin
            rd1_o   = wd_i;
            busy1_o = 1'b0;
        end
        if ((BYPASS != 0) && wr_ok && (wa_i == ra2_i)) begin
            rd2_o   = wd_i;
            busy2_o = 1'b0;
        end
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32: data word width in bits.
REQ-002 Parameter NREG, default 32: register count, a power of two, at least 2; AW = clog2(NREG).
REQ-003 Parameter BYPASS, default 1: 1 forwards the same-cycle write to the read ports; 0 returns the stored value.
REQ-004 Parameter ZERO_REG, default 1: 1 makes register 0 hardwired to zero; 0 makes it writable.
REQ-005 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-006 nreset_i  in  1  reset, asynchronous, active-low.
REQ-007 ra1_i  in  AW  read port 1 address.
REQ-008 rd1_o  out  XLEN  read port 1 data.
REQ-009 busy1_o  out  1  register ra1_i has a write pending.
REQ-010 ra2_i  in  AW  read port 2 address.
REQ-011 rd2_o  out  XLEN  read port 2 data.
REQ-012 busy2_o  out  1  register ra2_i has a write pending.
REQ-013 we_i  in  1  writeback enable.
REQ-014 wa_i  in  AW  writeback address.
REQ-015 wd_i  in  XLEN  writeback data.
REQ-016 iss_i  in  1  issue strobe: marks register iss_adr_i as pending.
REQ-017 iss_adr_i  in  AW  issue destination address.
REQ-018 busy_vec_o  out  NREG  full pending vector, bit i = register i.

Function
REQ-019 Reads SHALL be combinational, with zero-cycle latency from address to data.
REQ-020 On a rising edge with we_i=1, storage[wa_i] SHALL take wd_i, except wa_i=0 when ZERO_REG=1, which is dropped.
REQ-021 When ZERO_REG=1, register 0 SHALL read as 0 and SHALL never be pending.
REQ-022 When BYPASS=1 and we_i=1 and raN_i==wa_i (write not dropped), rdN_o SHALL be wd_i and busyN_o SHALL be 0 in that cycle.
REQ-023 When BYPASS=0, rdN_o SHALL be the stored value and busyN_o SHALL be the stored pending bit, so the written value is visible from the next cycle.
REQ-024 iss_i=1 SHALL set pending[iss_adr_i] at the edge; a not-dropped we_i=1 SHALL clear pending[wa_i] at the edge.
REQ-025 If iss_i and we_i target the same register in one cycle, set SHALL win: pending is 1 and data is written.
REQ-026 If iss_i targets a register that is already pending, the bit SHALL stay 1, with no count and no error.
REQ-027 Writeback to a register that is not pending SHALL be accepted: data written, pending stays 0.
REQ-028 Both read ports addressing the same register SHALL return identical data and busy.
REQ-029 Data width SHALL be exactly XLEN with no truncation or extension; addresses SHALL have no wrap, since the AW range equals NREG.
REQ-030 Reset asserted mid-operation SHALL override any we_i or iss_i in the same cycle.

Reset
REQ-031 While nreset_i=0, all storage SHALL be 0, all pending bits 0, and therefore rd1_o, rd2_o, busy1_o, busy2_o and busy_vec_o 0, unless bypass is active.
REQ-032 Reset SHALL take effect asynchronously on the falling edge of nreset_i; release SHALL be sampled synchronously with no extra latency.

Structure
REQ-033 A shared package SHALL hold the XLEN and NREG defaults, the AW derivation function, and the register-0 index constant.
REQ-034 Pending tracking SHALL be one sub-module, rf_scoreboard, with ports clk_i, nreset_i, set, set_adr, clr, clr_adr and vec; storage and bypass SHALL stay in regfile_sb.

Verification
REQ-035 Reset: drive nreset_i=0 mid-write with we_i=1, wa_i=5, wd_i=0xDEADBEEF; after release, reading 5 SHALL return 0 and busy_vec_o SHALL be 0.
REQ-036 Bypass (BYPASS=1): we_i=1, wa_i=3, wd_i=0x12345678, ra1_i=3 in the same cycle; rd1_o SHALL be 0x12345678 that cycle. With BYPASS=0, rd1_o SHALL be the old value that cycle and 0x12345678 the next.
REQ-037 Zero register (ZERO_REG=1): write 0xFFFFFFFF to 0 and issue 0; ra2_i=0 SHALL give rd2_o=0 and busy2_o=0.
REQ-038 Scoreboard: issue 7, then busy1_o=1 for ra1_i=7 the next cycle; writeback 7 with 0xA5, then busy1_o=0 and rd1_o=0xA5.
REQ-039 Collision: iss_i and we_i both to register 9 in one cycle; next cycle pending[9]=1 and the data equals wd_i.
REQ-040 Parameter sweep: XLEN=64, NREG=16, ZERO_REG=0; write and read all 16 registers with distinct 64-bit patterns, including writing 0x1 to register 0, which SHALL read back 0x1.
